// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int unsigned RELOCK_W = 8;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the reference clock domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses PLLRESET, waits for a stable lock, then releases
// the downstream domain resets one by one; retries on timeout and re-sequences on lock loss.
module pll_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned N_CH           = 3,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STAGE_GAP      = 8,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                clki_i,
    input  logic                rst_i,
    input  logic                lock_i,
    output logic                pll_rst_o,
    output logic [N_CH-1:0]     rst_o,
    output logic                ready_o,
    output logic                fail_o,
    output logic [RELOCK_W-1:0] relock_cnt_o
);

    localparam int unsigned PLL_W = $clog2(PLL_RST_CYCLES + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(STAGE_GAP + 1);
    localparam int unsigned STG_W = $clog2(N_CH + 1);
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    pll_state_t        state, state_nxt;
    logic [PLL_W-1:0]  pll_cnt, pll_cnt_nxt;
    logic [STB_W-1:0]  stb_cnt, stb_cnt_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic [STG_W-1:0]  stage, stage_nxt;
    logic [RTY_W-1:0]  retry, retry_nxt;

    logic                pll_rst_nxt;
    logic [N_CH-1:0]     rst_nxt;
    logic                ready_nxt;
    logic                fail_nxt;
    logic [RELOCK_W-1:0] relock_nxt;

    logic             lock_s;
    logic             stable_c;
    logic             timeout_c;
    logic             release_c;
    logic             last_stage_c;
    logic             lock_loss_c;
    logic [RTY_W-1:0] retry_inc_c;
    logic             retry_hit_c;

    pll_lock_sync u_lock_sync (
        .clk (clki_i),
        .rst (rst_i),
        .d   (lock_i),
        .q   (lock_s)
    );

    assign stable_c     = lock_s && (stb_cnt == STB_W'(LOCK_STABLE - 1));
    assign timeout_c    = (to_cnt == TO_W'(LOCK_TIMEOUT - 1));
    assign release_c    = (state == ST_RELEASE) && lock_s && (gap_cnt == GAP_W'(STAGE_GAP));
    assign last_stage_c = (stage == STG_W'(N_CH - 1));
    assign lock_loss_c  = ((state == ST_RELEASE) || (state == ST_RUN)) && !lock_s;
    assign retry_inc_c  = retry + RTY_W'(1);
    assign retry_hit_c  = (MAX_RETRY > 0) && (retry_inc_c == RTY_W'(MAX_RETRY));

    // State and sequencing counters
    always_ff @(posedge clki_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_RESET_PLL;
            pll_cnt <= '0;
            stb_cnt <= '0;
            to_cnt  <= '0;
            gap_cnt <= '0;
            stage   <= '0;
            retry   <= '0;
        end else begin
            state   <= state_nxt;
            pll_cnt <= pll_cnt_nxt;
            stb_cnt <= stb_cnt_nxt;
            to_cnt  <= to_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            stage   <= stage_nxt;
            retry   <= retry_nxt;
        end
    end

    // Next state; entering RESET_PLL from elsewhere counts the entry cycle as pulse cycle 1
    always_comb begin
        state_nxt   = state;
        pll_cnt_nxt = pll_cnt;
        stb_cnt_nxt = stb_cnt;
        to_cnt_nxt  = to_cnt;
        gap_cnt_nxt = gap_cnt;
        stage_nxt   = stage;
        retry_nxt   = retry;
        unique case (state)
            ST_RESET_PLL: begin
                if (pll_cnt == PLL_W'(PLL_RST_CYCLES)) begin
                    state_nxt   = ST_WAIT_LOCK;
                    stb_cnt_nxt = '0;
                    to_cnt_nxt  = '0;
                end else begin
                    pll_cnt_nxt = pll_cnt + PLL_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (stable_c) begin
                    state_nxt   = ST_RELEASE;
                    retry_nxt   = '0;
                    gap_cnt_nxt = GAP_W'(STAGE_GAP);
                    stage_nxt   = '0;
                end else if (timeout_c) begin
                    if (MAX_RETRY > 0) begin
                        retry_nxt = retry_inc_c;
                    end
                    if (retry_hit_c) begin
                        state_nxt = ST_FAIL;
                    end else begin
                        state_nxt   = ST_RESET_PLL;
                        pll_cnt_nxt = PLL_W'(1);
                    end
                end else begin
                    stb_cnt_nxt = lock_s ? stb_cnt + STB_W'(1) : '0;
                    to_cnt_nxt  = to_cnt + TO_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    state_nxt   = ST_RESET_PLL;
                    pll_cnt_nxt = PLL_W'(1);
                end else if (release_c) begin
                    gap_cnt_nxt = GAP_W'(1);
                    if (last_stage_c) begin
                        state_nxt = ST_RUN;
                    end else begin
                        stage_nxt = stage + STG_W'(1);
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt   = ST_RESET_PLL;
                    pll_cnt_nxt = PLL_W'(1);
                end
            end
            ST_FAIL: begin
                state_nxt = ST_FAIL;
            end
            default: begin
                state_nxt   = ST_RESET_PLL;
                pll_cnt_nxt = PLL_W'(1);
            end
        endcase
    end

    // Output next values, registered below
    always_comb begin
        pll_rst_nxt = (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAIL);
        fail_nxt    = (state_nxt == ST_FAIL);
        rst_nxt     = rst_o;
        ready_nxt   = ready_o;
        relock_nxt  = relock_cnt_o;
        if (lock_loss_c) begin
            rst_nxt   = '1;
            ready_nxt = 1'b0;
            if (relock_cnt_o != '1) begin
                relock_nxt = relock_cnt_o + RELOCK_W'(1);
            end
        end else if (release_c) begin
            for (int k = 0; k < int'(N_CH); k++) begin
                if (stage == STG_W'(k)) begin
                    rst_nxt[k] = 1'b0;
                end
            end
            if (last_stage_c) begin
                ready_nxt = 1'b1;
            end
        end else if ((state_nxt != ST_RELEASE) && (state_nxt != ST_RUN)) begin
            rst_nxt   = '1;
            ready_nxt = 1'b0;
        end
    end

    always_ff @(posedge clki_i or posedge rst_i) begin
        if (rst_i) begin
            pll_rst_o    <= 1'b1;
            rst_o        <= '1;
            ready_o      <= 1'b0;
            fail_o       <= 1'b0;
            relock_cnt_o <= '0;
        end else begin
            pll_rst_o    <= pll_rst_nxt;
            rst_o        <= rst_nxt;
            ready_o      <= ready_nxt;
            fail_o       <= fail_nxt;
            relock_cnt_o <= relock_nxt;
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Randomized bench for pll_rst_seq against a timestamp-based reference model.
module tb_pll_rst_seq;

    localparam int unsigned N_CH = 3;
    localparam int unsigned PRC  = 4;
    localparam int unsigned LS   = 8;
    localparam int unsigned LT   = 32;
    localparam int unsigned SG   = 2;
    localparam int unsigned MR   = 2;

    localparam int M_PULSE = 0;
    localparam int M_WAIT  = 1;
    localparam int M_REL   = 2;
    localparam int M_FAIL  = 3;

    logic            clk;
    logic            rst;
    logic            lock;
    logic            pll_rst;
    logic [N_CH-1:0] rst_vec;
    logic            ready;
    logic            fail;
    logic [7:0]      relock_cnt;

    int n_chk;
    int n_pass;

    int edge_n;
    bit li[$];
    int m_mode;
    int m_t0;
    int m_retries;
    int m_relocks;

    pll_rst_seq #(
        .N_CH           (N_CH),
        .PLL_RST_CYCLES (PRC),
        .LOCK_STABLE    (LS),
        .LOCK_TIMEOUT   (LT),
        .STAGE_GAP      (SG),
        .MAX_RETRY      (MR)
    ) dut (
        .clki_i       (clk),
        .rst_i        (rst),
        .lock_i       (lock),
        .pll_rst_o    (pll_rst),
        .rst_o        (rst_vec),
        .ready_o      (ready),
        .fail_o       (fail),
        .relock_cnt_o (relock_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, edge_n, $time);
    endtask

    // Synchronized lock as seen by the sequencer at edge p (two edges of latency)
    function automatic bit ls_at(input int p);
        if (p < 3) return 1'b0;
        return li[p-3];
    endfunction

    task automatic model_reset();
        edge_n    = 0;
        li.delete();
        m_mode    = M_PULSE;
        m_t0      = 1;
        m_retries = 0;
        m_relocks = 0;
    endtask

    task automatic model_edge();
        int p;
        bit all_hi;
        p = edge_n;
        case (m_mode)
            M_PULSE: begin
                if (p == m_t0 + int'(PRC)) begin
                    m_mode = M_WAIT;
                    m_t0   = p;
                end
            end
            M_WAIT: begin
                all_hi = (p - m_t0 >= int'(LS));
                for (int q = p - int'(LS) + 1; q <= p; q++)
                    if (!ls_at(q)) all_hi = 1'b0;
                if (all_hi) begin
                    m_mode    = M_REL;
                    m_t0      = p;
                    m_retries = 0;
                end else if (p == m_t0 + int'(LT)) begin
                    m_retries++;
                    if (m_retries == int'(MR)) m_mode = M_FAIL;
                    else begin
                        m_mode = M_PULSE;
                        m_t0   = p;
                    end
                end
            end
            M_REL: begin
                if (!ls_at(p)) begin
                    m_mode = M_PULSE;
                    m_t0   = p;
                    if (m_relocks < 255) m_relocks++;
                end
            end
            default: ;
        endcase
    endtask

    function automatic bit exp_ready();
        return (m_mode == M_REL) && (edge_n >= m_t0 + 1 + int'((N_CH - 1) * SG));
    endfunction

    task automatic compare_all();
        logic [N_CH-1:0] e_rst;
        e_rst = '1;
        if (m_mode == M_REL)
            for (int k = 0; k < int'(N_CH); k++)
                if (edge_n >= m_t0 + 1 + k * int'(SG)) e_rst[k] = 1'b0;
        check("pll_rst_o", 32'(pll_rst), 32'((m_mode == M_PULSE) || (m_mode == M_FAIL)));
        check("rst_o", 32'(rst_vec), 32'(e_rst));
        check("ready_o", 32'(ready), 32'(exp_ready()));
        check("fail_o", 32'(fail), 32'(m_mode == M_FAIL));
        check("relock_cnt_o", 32'(relock_cnt), 32'(m_relocks));
    endtask

    task automatic step(input bit l);
        lock = l;
        @(posedge clk);
        edge_n++;
        li.push_back(l);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Called at a falling edge; reset takes effect asynchronously
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_rst_relock", 32'(relock_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        int dl;
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        lock   = 1'b0;
        model_reset();
        @(negedge clk);

        // Normal bring-up, lock rises at edge 10
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            step(c >= 10);
            if (c == 4)  check("bringup_pll_c4", 32'(pll_rst), 32'd1);
            if (c == 5)  check("bringup_pll_c5", 32'(pll_rst), 32'd0);
            if (c == 19) check("bringup_rst_c19", 32'(rst_vec), 32'h7);
            if (c == 20) check("bringup_rst_c20", 32'(rst_vec), 32'h6);
            if (c == 22) check("bringup_rst_c22", 32'(rst_vec), 32'h4);
            if (c == 23) check("bringup_rdy_c23", 32'(ready), 32'd0);
            if (c == 24) check("bringup_rst_c24", 32'(rst_vec), 32'h0);
            if (c == 24) check("bringup_rdy_c24", 32'(ready), 32'd1);
        end

        // Glitchy lock: 5 high, 1 low, then high from edge 16
        do_reset();
        for (int c = 1; c <= 35; c++) begin
            step((c >= 10) && (c != 15));
            if (c == 25) check("glitch_rst_c25", 32'(rst_vec), 32'h7);
            if (c == 26) check("glitch_rst_c26", 32'(rst_vec), 32'h6);
        end

        // Lock never arrives: retry once, then fail
        do_reset();
        for (int c = 1; c <= 90; c++) begin
            step(1'b0);
            if (c == 36) check("tmo_pll_c36", 32'(pll_rst), 32'd0);
            if (c == 37) check("tmo_pll_c37", 32'(pll_rst), 32'd1);
            if (c == 41) check("tmo_pll_c41", 32'(pll_rst), 32'd0);
            if (c == 72) check("tmo_fail_c72", 32'(fail), 32'd0);
            if (c == 73) check("tmo_fail_c73", 32'(fail), 32'd1);
            if (c == 90) check("tmo_rst_c90", 32'(rst_vec), 32'h7);
        end

        // Reset out of FAIL, lock loss in RUN, then reset mid-release
        do_reset();
        for (int c = 1; c <= 57; c++) begin
            step(!((c >= 41) && (c <= 43)));
            if (c == 18) check("run_rdy_c18", 32'(ready), 32'd1);
            if (c == 43) check("loss_relock_c43", 32'(relock_cnt), 32'd1);
            if (c == 43) check("loss_rst_c43", 32'(rst_vec), 32'h7);
            if (c == 43) check("loss_pll_c43", 32'(pll_rst), 32'd1);
            if (c == 57) check("rerel_rst_c57", 32'(rst_vec), 32'h6);
        end
        do_reset();

        // Random lock, mostly high with sporadic drops
        for (int c = 1; c <= 600; c++)
            step($urandom_range(0, 99) < 93);

        // Saturation of the lock-loss counter
        do_reset();
        for (int c = 0; c < 25; c++) step(1'b1);
        for (int i = 0; i < 260; i++) begin
            dl = int'($urandom_range(1, 3));
            for (int c = 0; c < dl; c++) step(1'b0);
            for (int c = 0; c < 24; c++) step(1'b1);
        end
        check("relock_saturated", 32'(relock_cnt), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
